iob_mask_pipe: RTL and testbench
================================

Name: iob_mask_pipe

Overview:
- Pipelined, parametrised mask generator for the float/posit datapath. Successor to the combinational low-ones mask.
- Produces four mask shapes: low, high, bit-range and inverted range. Handles saturating and truncating lengths.
- Two-stage valid/ready pipeline with full backpressure, so it slots between normaliser and rounding stages.
- Optional apply stage ANDs the mask onto a data word and emits a sticky bit for rounding.

Parameters:
- DATA_W, 32, mask/data width in bits (>= 2).
- LEN_W, $clog2(DATA_W+1), width of the length/offset fields. Must hold the value DATA_W.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  input request valid
- ready_o  out  1  block can accept a request this cycle
- mode_i  in  2  0=LOW, 1=HIGH, 2=RANGE, 3=NRANGE
- lo_i  in  LEN_W  range start bit (RANGE/NRANGE only; ignored otherwise)
- len_i  in  LEN_W  number of ones
- data_i  in  DATA_W  word to mask (present only with feature)
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- mask_o  out  DATA_W  generated mask
- data_o  out  DATA_W  data_i AND mask (present only with feature)
- sticky_o  out  1  OR of data_i bits outside the mask (present only with feature)

Behaviour:
- Input transfer on valid_i & ready_o. Output transfer on valid_o & ready_i. Fields are sampled only on transfer.
- Stage 1 (S1) registers the decoded request: mode, clamped len, clamped lo and, with the feature, data.
- Stage 2 (S2) registers the final mask and outputs.
- Latency: 2 cycles, transfer to valid_o, when unstalled. Throughput: 1 per cycle.
- Each stage has a valid flag. A stage loads when it is empty or its contents move forward in the same cycle.
- ready_o = !s1_valid | !s2_valid | ready_i.
- No combinational path from valid_i to valid_o. A path from ready_i to ready_o is allowed.
- Simultaneous input and output transfer with both stages full: S2 takes S1 and S1 takes the new request. No loss and no duplication; order is strictly preserved.
- Mask arithmetic, with L = min(len_i, DATA_W):
  - LOW: bits [L-1:0] set.
  - HIGH: bits [DATA_W-1:DATA_W-L] set.
  - RANGE: bits [lo_i+len_i-1:lo_i] set. Bits at index >= DATA_W are dropped (no wrap). lo_i >= DATA_W gives all zeros.
  - NRANGE: bitwise inverse of RANGE.
  - len_i = 0: all zeros for LOW/HIGH/RANGE, all ones for NRANGE.
- Sum lo_i+len_i is computed at LEN_W+1 bits, so it never overflows.
- Reset: s1_valid=0, s2_valid=0, valid_o=0, mask_o=0, data_o=0, sticky_o=0. ready_o=1 from the first cycle after reset.
- Reset mid-operation discards all in-flight requests; nothing emerges afterwards.
- mask_o/data_o/sticky_o hold their values while valid_o=1 and ready_i=0.
- Contents are don't-care when valid_o=0, but must not change without a transfer.

Optional Feature:
- Macro IOB_MASK_PIPE_APPLY_EN.
- Defined:
  - data_i/data_o/sticky_o ports exist. data_i travels through S1.
  - data_o = data & mask. sticky_o = |(data & ~mask). Both are aligned with mask_o in S2 and reset to 0.
- Undefined:
  - Ports, data registers and logic are absent. Mask behaviour and timing are identical.

Test Plan (DATA_W=8):
- Single request per mode, ready_i=1 -> valid_o exactly 2 cycles after the transfer, with:
  - LOW len=3 -> 0x07.
  - HIGH len=3 -> 0xE0.
  - RANGE lo=2 len=3 -> 0x1C.
  - NRANGE lo=2 len=3 -> 0xE3.
- Boundaries:
  - LOW len=0 -> 0x00.
  - LOW len=8 -> 0xFF.
  - LOW len=9 -> 0xFF (saturated).
  - RANGE lo=6 len=5 -> 0xC0 (truncated).
  - RANGE lo=8 len=1 -> 0x00.
  - NRANGE len=0 -> 0xFF.
- Backpressure:
  - Stream LOW len=1,2,3,4 back-to-back with ready_i=0 for 4 cycles -> ready_o drops after 2 accepted; mask_o holds 0x01.
  - Release ready_i -> outputs 0x01,0x03,0x07,0x0F in order, once each.
- Full throughput: 16 consecutive requests with ready_i=1 -> ready_o stays 1 and 16 results arrive on 16 consecutive cycles.
- Reset mid-operation: assert rst_i for 1 cycle with both stages full -> valid_o=0 and mask_o=0 the next cycle, no stale result afterwards, ready_o=1.
- Feature on: data_i=0xB5, LOW len=4 -> mask_o=0x0F, data_o=0x05, sticky_o=1. Same request with data_i=0x05 -> sticky_o=0.

Source files
------------

// File: rtl/iob_mask_pipe.sv
// iob_mask_pipe
//   Two-stage valid/ready pipelined mask generator for the float/posit datapath.
//   Produces LOW, HIGH, RANGE and NRANGE mask shapes with saturating lengths
//   and truncating ranges. There is full backpressure and a throughput of one
//   request per cycle.
//
//   Optional feature macro: IOB_MASK_PIPE_APPLY_EN
//     When it is defined, the mask is ANDed onto data_i. A sticky bit reports
//     any data bits that the mask discards.
//
// Parameters
//   DATA_W : mask/data width in bits (>= 2)
//   LEN_W  : width of the lo/len fields; it must be able to hold DATA_W
//
// Ports
//   clk_i, rst_i     : clock, synchronous active-high reset
//   valid_i, ready_o : request handshake
//   mode_i           : 0=LOW 1=HIGH 2=RANGE 3=NRANGE
//   lo_i, len_i      : range start bit, number of ones
//   data_i           : word to mask (feature only)
//   valid_o, ready_i : result handshake
//   mask_o           : generated mask
//   data_o, sticky_o : masked word, OR of discarded bits (feature only)

module iob_mask_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [1:0]        mode_i,
    input  logic [LEN_W-1:0]  lo_i,
    input  logic [LEN_W-1:0]  len_i,
`ifdef IOB_MASK_PIPE_APPLY_EN
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              sticky_o,
`endif
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] mask_o
);

    typedef enum logic [1:0] {
        MODE_LOW    = 2'd0,
        MODE_HIGH   = 2'd1,
        MODE_RANGE  = 2'd2,
        MODE_NRANGE = 2'd3
    } mode_t;

    localparam logic [LEN_W-1:0] W_L = LEN_W'(DATA_W);

    // Bits [n-1:0] set; n >= DATA_W gives all ones.
    function automatic logic [DATA_W-1:0] ones_below(input logic [LEN_W:0] n);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            m[i] = ((LEN_W + 1)'(i) < n);
        end
        return m;
    endfunction

    // Handshake
    logic s1_valid, s2_valid;
    logic s1_ready, s2_ready;

    assign s2_ready = !s2_valid || ready_i;
    assign s1_ready = !s1_valid || s2_ready;
    assign ready_o  = s1_ready;
    assign valid_o  = s2_valid;

    // Stage 1: clamped request
    logic [LEN_W-1:0] len_c, lo_c;
    mode_t            s1_mode;
    logic [LEN_W-1:0] s1_len, s1_lo;

    // Clamping lo to DATA_W keeps lo+len within LEN_W+1 bits. It also keeps
    // an out-of-range start producing an empty range.
    assign len_c = (len_i > W_L) ? W_L : len_i;
    assign lo_c  = (lo_i  > W_L) ? W_L : lo_i;

    // Stage 2: mask decode from the registered request
    logic [LEN_W:0]    end_c;
    logic [DATA_W-1:0] range_m;
    logic [DATA_W-1:0] mask_nxt;
    logic [DATA_W-1:0] s2_mask;

    assign end_c   = {1'b0, s1_lo} + {1'b0, s1_len};
    assign range_m = ones_below(end_c) & ~ones_below({1'b0, s1_lo});

    always_comb begin
        mask_nxt = '0;
        unique case (s1_mode)
            MODE_LOW:    mask_nxt = ones_below({1'b0, s1_len});
            MODE_HIGH:   mask_nxt = ~ones_below({1'b0, W_L} - {1'b0, s1_len});
            MODE_RANGE:  mask_nxt = range_m;
            MODE_NRANGE: mask_nxt = ~range_m;
            default:     mask_nxt = '0;
        endcase
    end

`ifdef IOB_MASK_PIPE_APPLY_EN
    logic [DATA_W-1:0] s1_data;
    logic [DATA_W-1:0] s2_data;
    logic              s2_sticky;
    logic [DATA_W-1:0] data_nxt;
    logic              sticky_nxt;

    assign data_nxt   = s1_data & mask_nxt;
    assign sticky_nxt = |(s1_data & ~mask_nxt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_data   <= '0;
            s2_data   <= '0;
            s2_sticky <= 1'b0;
        end else begin
            if (ready_o && valid_i) begin
                s1_data <= data_i;
            end
            if (s2_ready && s1_valid) begin
                s2_data   <= data_nxt;
                s2_sticky <= sticky_nxt;
            end
        end
    end

    assign data_o   = s2_data;
    assign sticky_o = s2_sticky;
`endif

    // Each stage loads when it is empty or when its contents move forward in
    // the same cycle. Payload registers change only on an actual transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_LOW;
            s1_len   <= '0;
            s1_lo    <= '0;
            s2_valid <= 1'b0;
            s2_mask  <= '0;
        end else begin
            if (ready_o) begin
                s1_valid <= valid_i;
                if (valid_i) begin
                    s1_mode <= mode_t'(mode_i);
                    s1_len  <= len_c;
                    s1_lo   <= lo_c;
                end
            end
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_mask <= mask_nxt;
                end
            end
        end
    end

    assign mask_o = s2_mask;

endmodule

// File: tb/tb_iob_mask_pipe.sv
module tb_iob_mask_pipe;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              valid_i;
    logic              ready_o;
    logic [1:0]        mode_i;
    logic [LEN_W-1:0]  lo_i;
    logic [LEN_W-1:0]  len_i;
    logic [DATA_W-1:0] data_v;
    logic              valid_o;
    logic              ready_i;
    logic [DATA_W-1:0] mask_o;
`ifdef IOB_MASK_PIPE_APPLY_EN
    logic [DATA_W-1:0] data_o;
    logic              sticky_o;
`endif

    iob_mask_pipe #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .mode_i  (mode_i),
        .lo_i    (lo_i),
        .len_i   (len_i),
`ifdef IOB_MASK_PIPE_APPLY_EN
        .data_i  (data_v),
        .data_o  (data_o),
        .sticky_o(sticky_o),
`endif
        .valid_o (valid_o),
        .ready_i (ready_i),
        .mask_o  (mask_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] data;
        logic              sticky;
        int                cyc;
        bit                exact;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   rnd_ready = 0;
    bit   exact_lat = 0;

    // Reference model: each bit is decided directly from the mode rules.
    function automatic logic [DATA_W-1:0] ref_mask(int mode, int lo, int len);
        logic [DATA_W-1:0] m;
        int L;
        bit in_range;
        L = (len > DATA_W) ? DATA_W : len;
        m = '0;
        for (int i = 0; i < DATA_W; i++) begin
            in_range = (i >= lo) && (i < lo + len);
            case (mode)
                0: m[i] = (i < L);
                1: m[i] = (i >= DATA_W - L);
                2: m[i] = in_range;
                default: m[i] = !in_range;
            endcase
        end
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) ready_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drive(input int mode, input int lo, input int len, input int d);
        valid_i = 1'b1;
        mode_i  = 2'(mode);
        lo_i    = LEN_W'(lo);
        len_i   = LEN_W'(len);
        data_v  = DATA_W'(d);
    endtask

    // Holds the current request until it is accepted, then records its expected result.
    task automatic wait_accept(output bit first_try);
        exp_t e;
        first_try = 1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (ready_o) begin
                e.mask   = ref_mask(int'(mode_i), int'(lo_i), int'(len_i));
                e.data   = data_v & e.mask;
                e.sticky = |(data_v & ~e.mask);
                e.cyc    = cyc;
                e.exact  = exact_lat;
                sb.push_back(e);
                return;
            end
            first_try = 0;
            tick();
        end
        chk("accept_timeout", 32'(ready_o), 32'd1);
    endtask

    task automatic send(input int mode, input int lo, input int len, input int d);
        bit ft;
        tick();
        drive(mode, lo, len, d);
        wait_accept(ft);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            valid_i = 1'b0;
        end
    endtask

    // Directed vectors: mode, lo, len, data
    int dir_v[16][4] = '{
        '{0, 0, 3, 8'hB5}, '{1, 0, 3, 8'h5A}, '{2, 2, 3, 8'hFF}, '{3, 2, 3, 8'h3C},
        '{0, 0, 0, 8'h11}, '{0, 0, 8, 8'h81}, '{0, 0, 9, 8'h7E}, '{2, 6, 5, 8'hC3},
        '{2, 8, 1, 8'hFF}, '{3, 4, 0, 8'h00}, '{1, 0, 15, 8'hA5}, '{2, 15, 15, 8'hFF},
        '{3, 0, 8, 8'h0F}, '{1, 0, 0, 8'hF0}, '{0, 0, 4, 8'hB5}, '{0, 0, 4, 8'h05}
    };

    // Spot checks on the reference itself against the documented values.
    int spot_v[10][4] = '{
        '{0, 0, 3, 8'h07}, '{1, 0, 3, 8'hE0}, '{2, 2, 3, 8'h1C}, '{3, 2, 3, 8'hE3},
        '{0, 0, 0, 8'h00}, '{0, 0, 8, 8'hFF}, '{0, 0, 9, 8'hFF}, '{2, 6, 5, 8'hC0},
        '{2, 8, 1, 8'h00}, '{3, 0, 0, 8'hFF}
    };

    initial begin
        bit ft;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        mode_i  = '0;
        lo_i    = '0;
        len_i   = '0;
        data_v  = '0;

        // The monitor pops and compares whenever the DUT hands over a result.
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (!rst_i && valid_o) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out", 32'(valid_o), 32'd0);
                    end else if (ready_i) begin
                        e = sb.pop_front();
                        chk("mask", 32'(mask_o), 32'(e.mask));
`ifdef IOB_MASK_PIPE_APPLY_EN
                        chk("data", 32'(data_o), 32'(e.data));
                        chk("sticky", 32'(sticky_o), 32'(e.sticky));
`endif
                        if (e.exact) chk("latency", 32'(cyc - e.cyc), 32'd2);
                        else         chk("latency_min", 32'(cyc - e.cyc >= 2), 32'd1);
                    end else begin
                        chk("hold_mask", 32'(mask_o), 32'(sb[0].mask));
                    end
                end
            end
        join_none

        for (int i = 0; i < 10; i++)
            chk("ref_spot", 32'(ref_mask(spot_v[i][0], spot_v[i][1], spot_v[i][2])), 32'(spot_v[i][3]));

        // Reset state
        repeat (3) tick();
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_mask_o", 32'(mask_o), 32'd0);
        chk("rst_ready_o", 32'(ready_o), 32'd1);
`ifdef IOB_MASK_PIPE_APPLY_EN
        chk("rst_data_o", 32'(data_o), 32'd0);
        chk("rst_sticky_o", 32'(sticky_o), 32'd0);
`endif

        // Single requests, unstalled: latency is exactly 2
        ready_i   = 1'b1;
        exact_lat = 1;
        for (int i = 0; i < 16; i++) begin
            send(dir_v[i][0], dir_v[i][1], dir_v[i][2], dir_v[i][3]);
            idle(3);
        end

        // Full throughput: 16 back-to-back requests
        for (int i = 0; i < 16; i++) begin
            tick();
            drive($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255));
            wait_accept(ft);
            chk("thru_ready", 32'(ft), 32'd1);
        end
        idle(4);
        exact_lat = 0;

        // Backpressure: ready_i low for 4 cycles while LOW 1..4 streams in
        tick();
        ready_i = 1'b0;
        drive(0, 0, 1, 0);
        wait_accept(ft);
        send(0, 0, 2, 0);
        tick();
        drive(0, 0, 3, 0);
        @(negedge clk);
        chk("bp_ready_low", 32'(ready_o), 32'd0);
        chk("bp_mask_hold", 32'(mask_o), 32'h01);
        tick();
        @(negedge clk);
        chk("bp_ready_low2", 32'(ready_o), 32'd0);
        chk("bp_mask_hold2", 32'(mask_o), 32'h01);
        tick();
        ready_i = 1'b1;
        wait_accept(ft);
        send(0, 0, 4, 0);
        idle(6);
        chk("bp_drained", 32'(sb.size()), 32'd0);

        // Reset with both stages full
        tick();
        ready_i = 1'b0;
        drive(0, 0, 3, 0);
        wait_accept(ft);
        send(0, 0, 5, 0);
        tick();
        valid_i = 1'b0;
        rst_i   = 1'b1;
        sb.delete();
        tick();
        rst_i   = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        chk("midrst_valid_o", 32'(valid_o), 32'd0);
        chk("midrst_mask_o", 32'(mask_o), 32'd0);
        chk("midrst_ready_o", 32'(ready_o), 32'd1);
        idle(8);

        // Randomised traffic with random backpressure
        rnd_ready = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else send($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255));
        end
        rnd_ready = 0;

        // Drain
        tick();
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int n = 0; n < 30 && sb.size() != 0; n++) @(negedge clk);
        idle(2);
        chk("final_drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
